debug_tx: RTL and testbench
===========================

DEBUG_TX -- requirements
Module: debug_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, clock cycles per UART bit (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port debug  input  1  debug mode enable; transmission only while high.
REQ-005 SHALL have port snap_valid  input  1  one-cycle strobe: debug_frame/debug_reg carry a new snapshot.
REQ-006 SHALL have port debug_frame  input  9  captured 9-bit receive frame.
REQ-007 SHALL have port debug_reg  input  4  captured register value.
REQ-008 SHALL have port tx  output  1  UART serial output, idle high.
REQ-009 SHALL have port busy  output  1  high while a packet is being transmitted.
REQ-010 SHALL have port overrun  output  1  sticky flag: a pending snapshot was overwritten.

Function
REQ-011 SHALL transmit each snapshot as a 3-byte packet: B0 = 0x55 sync, B1 = debug_frame[7:0], B2 = {3'b000, debug_frame[8], debug_reg}.
REQ-012 SHALL frame every byte as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each exactly CLKS_PER_BIT cycles; no idle gap between bytes of a packet.
REQ-013 SHALL use states IDLE, START, DATA, STOP; IDLE->START on accept; START->DATA after one bit time; DATA->STOP after bit index 7; STOP->START if byte index < 2, else STOP->START for a pending snapshot, else STOP->IDLE.
REQ-014 SHALL accept snap_valid only when debug=1; in IDLE, snap_valid high at edge k latches the snapshot, and tx=0 and busy=1 from edge k+1.
REQ-015 SHALL latch debug_frame/debug_reg at acceptance; later input changes SHALL NOT affect the packet in flight.
REQ-016 SHALL hold one pending snapshot: snap_valid while busy stores into the pending slot; if the slot is already full, it SHALL be overwritten with the newer snapshot and overrun set to 1.
REQ-017 SHALL launch the pending snapshot with the start bit in the cycle immediately after B2's stop bit ends; busy SHALL remain high throughout.
REQ-018 SHALL, when busy and not pending, deassert busy and return tx=1 in the cycle after B2's stop bit ends.
REQ-019 SHALL, on debug falling mid-packet, complete the current packet, discard any pending snapshot, and ignore snap_valid until debug=1 again.
REQ-020 SHALL keep the baud counter width ceil(log2(CLKS_PER_BIT)) and restart it at 0 on every bit boundary; no drift over a packet (packet = 30*CLKS_PER_BIT cycles exactly).
REQ-021 SHALL give snap_valid and debug falling in the same cycle: snapshot not accepted.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, force state IDLE, tx=1, busy=0, overrun=0, pending slot empty, counters 0, regardless of activity; rst has priority over all inputs.
REQ-023 SHALL, when reset arrives mid-bit, abort the packet with tx=1 from the next edge; no partial byte resumed.

Structure
REQ-024 SHALL place state encoding, SYNC_BYTE (0x55), and the CLKS_PER_BIT default in a shared package debug_pkg.
REQ-025 SHALL be split into a top-level packet sequencer (snapshot latch, pending slot, byte index, overrun) and one sub-module uart_tx_byte (baud counter, bit shifter, start/stop framing, byte_done strobe).
REQ-026 SHALL register tx directly from a flip-flop (no combinational glitches on the serial line).

Verification (CLKS_PER_BIT=4)
REQ-027 SHALL cover: reset, debug=0, snap_valid pulses -> tx stays 1, busy stays 0 for 200 cycles.
REQ-028 SHALL cover: debug=1, frame=9'b010101010, reg=4'b0101, one pulse -> bytes 0x55, 0xAA, 0x05 decoded on tx, busy high exactly 120 cycles.
REQ-029 SHALL cover: frame=9'b101010101, reg=4'b1111 -> B1=0x55, B2=0x1F; inputs changed to 0 one cycle after accept do not alter the bytes.
REQ-030 SHALL cover: two pulses during packet A (snapshots B then C) -> packet A then C back-to-back, busy never drops, overrun=1.
REQ-031 SHALL cover: debug dropped during B1 with one pending -> packet completes, pending dropped, busy=0 at 120 cycles after accept.
REQ-032 SHALL cover: rst asserted mid-B1 -> tx=1, busy=0, overrun=0 on next edge; new pulse afterwards sends a clean full packet.

Source files
------------

// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared constants, serializer state encoding and byte helpers for debug_tx
package debug_pkg;

    localparam int         CLKS_PER_BIT_DEFAULT = 10416;
    localparam logic [7:0] SYNC_BYTE            = 8'h55;
    localparam logic [1:0] LAST_BYTE_IDX        = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Third packet byte: frame bit 8 alongside the captured register value.
    function automatic logic [7:0] status_byte(input logic frame_msb, input logic [3:0] reg_val);
        return {3'b000, frame_msb, reg_val};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with back-to-back byte chaining
module uart_tx_byte
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tdata,
    input  logic       tvalid,
    output logic       tready,
    output logic       tx,
    output logic       active,
    output logic       byte_done
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_q, tx_n;
    logic          bit_end;

    assign bit_end   = (cnt == CNT_MAX);
    assign byte_done = (state == STOP) && bit_end;
    // A new byte is taken either from idle or exactly as the stop bit ends, so bytes chain with no gap.
    assign tready    = (state == IDLE) || byte_done;
    assign active    = (state != IDLE);
    assign tx        = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx_q    <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = bit_end ? '0 : cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        tx_n      = tx_q;
        case (state)
            IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
                if (tvalid) begin
                    state_n = START;
                    tx_n    = 1'b0;
                    shreg_n = tdata;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    tx_n      = shreg[0];
                    shreg_n   = {1'b0, shreg[7:1]};
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        tx_n      = shreg[0];
                        shreg_n   = {1'b0, shreg[7:1]};
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (tvalid) begin
                        state_n = START;
                        tx_n    = 1'b0;
                        shreg_n = tdata;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/debug_tx.sv
// rtl/debug_tx.sv - debug snapshot packet sequencer driving a UART byte serializer
module debug_tx
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       debug,
    input  logic       snap_valid,
    input  logic [8:0] debug_frame,
    input  logic [3:0] debug_reg,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    logic [8:0] cur_frame;
    logic [3:0] cur_reg;
    logic [1:0] byte_idx;
    logic       pend_valid;
    logic [8:0] pend_frame;
    logic [3:0] pend_reg;
    logic       overrun_q;

    logic       byte_tready;
    logic       byte_done;
    logic       byte_tvalid;
    logic [7:0] byte_tdata;

    logic accept;
    logic next_byte;
    logic final_done;
    logic launch_pend;
    logic launch_new;
    logic store_pend;

    always_comb begin
        accept      = debug && snap_valid;
        next_byte   = byte_done && (byte_idx != LAST_BYTE_IDX);
        final_done  = byte_done && (byte_idx == LAST_BYTE_IDX);
        launch_pend = final_done && pend_valid && debug;
        // A snapshot arriving as the last stop bit ends with an empty slot goes straight out.
        launch_new  = accept && byte_tready && !next_byte && !launch_pend;
        store_pend  = accept && !launch_new;
        byte_tvalid = launch_new || launch_pend || next_byte;
        byte_tdata  = SYNC_BYTE;
        if (next_byte) begin
            byte_tdata = (byte_idx == 2'd0) ? cur_frame[7:0] : status_byte(cur_frame[8], cur_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_frame  <= '0;
            cur_reg    <= '0;
            byte_idx   <= '0;
            pend_valid <= 1'b0;
            pend_frame <= '0;
            pend_reg   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (launch_new) begin
                cur_frame <= debug_frame;
                cur_reg   <= debug_reg;
                byte_idx  <= '0;
            end else if (launch_pend) begin
                cur_frame <= pend_frame;
                cur_reg   <= pend_reg;
                byte_idx  <= '0;
            end else if (next_byte) begin
                byte_idx <= byte_idx + 1'b1;
            end

            if (store_pend) begin
                pend_frame <= debug_frame;
                pend_reg   <= debug_reg;
            end

            // Dropping debug discards whatever is waiting; the packet in flight still completes.
            if (!debug) begin
                pend_valid <= 1'b0;
            end else if (store_pend) begin
                pend_valid <= 1'b1;
            end else if (launch_pend) begin
                pend_valid <= 1'b0;
            end

            if (store_pend && pend_valid && !launch_pend) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign overrun = overrun_q;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk      (clk),
        .rst      (rst),
        .tdata    (byte_tdata),
        .tvalid   (byte_tvalid),
        .tready   (byte_tready),
        .tx       (tx),
        .active   (busy),
        .byte_done(byte_done)
    );

endmodule

// File: tb/tb_debug_tx.sv
// tb/tb_debug_tx.sv - self-checking bench for debug_tx with a snapshot/packet reference model
module tb_debug_tx;

    localparam int CPB        = 4;
    localparam int PKT_CYCLES = 30 * CPB;
    localparam int ACT_SNAP    = 0;
    localparam int ACT_DBG_OFF = 1;
    localparam int ACT_ZERO_IN = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       debug;
    logic       snap_valid;
    logic [8:0] debug_frame;
    logic [3:0] debug_reg;
    logic       tx;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    bit         pend_valid_m = 1'b0;
    logic [8:0] pend_f_m     = '0;
    logic [3:0] pend_r_m     = '0;
    logic       overrun_m    = 1'b0;

    typedef struct {
        int         m;
        int         kind;
        logic [8:0] f;
        logic [3:0] r;
    } act_t;
    act_t acts[$];

    debug_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .debug      (debug),
        .snap_valid (snap_valid),
        .debug_frame(debug_frame),
        .debug_reg  (debug_reg),
        .tx         (tx),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_bit(input logic obs, input logic exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pkt_byte(input logic [8:0] f, input logic [3:0] r, input int idx);
        logic [7:0] b;
        case (idx)
            0:       b = 8'h55;
            1:       b = f[7:0];
            default: b = {3'b000, f[8], r};
        endcase
        return b;
    endfunction

    task automatic add_act(input int m, input int kind, input logic [8:0] f, input logic [3:0] r);
        act_t a;
        a.m    = m;
        a.kind = kind;
        a.f    = f;
        a.r    = r;
        acts.push_back(a);
    endtask

    task automatic apply(input act_t a);
        case (a.kind)
            ACT_SNAP: begin
                debug_frame = a.f;
                debug_reg   = a.r;
                snap_valid  = 1'b1;
                if (debug) begin
                    if (pend_valid_m) overrun_m = 1'b1;
                    pend_valid_m = 1'b1;
                    pend_f_m     = a.f;
                    pend_r_m     = a.r;
                end
            end
            ACT_DBG_OFF: begin
                debug        = 1'b0;
                pend_valid_m = 1'b0;
            end
            default: begin
                debug_frame = '0;
                debug_reg   = '0;
            end
        endcase
    endtask

    // Entered at the negedge right after the accepting edge; decodes 30 bit cells at their centres.
    task automatic recv(input logic [8:0] f, input logic [3:0] r, input string tag);
        logic [7:0] got [3];
        int j, b, i;
        for (int k = 0; k < 3; k++) got[k] = 'x;
        for (int m = 0; m < PKT_CYCLES; m++) begin
            if (m > 0) cyc();
            if (m == 0) begin
                check_bit(tx, 1'b0, {tag, " tx low after accept"});
                check_bit(busy, 1'b1, {tag, " busy after accept"});
            end
            if (m % CPB == CPB / 2) begin
                j = m / CPB;
                b = j / 10;
                i = j % 10;
                check_bit(busy, 1'b1, $sformatf("%s busy bit%0d", tag, j));
                if (i == 0)      check_bit(tx, 1'b0, $sformatf("%s start bit byte%0d", tag, b));
                else if (i == 9) check_bit(tx, 1'b1, $sformatf("%s stop bit byte%0d", tag, b));
                else             got[b][i-1] = tx;
            end
            if (m == PKT_CYCLES - 1) check_bit(busy, 1'b1, {tag, " busy last cycle"});
            snap_valid = 1'b0;
            foreach (acts[a]) if (acts[a].m == m) apply(acts[a]);
        end
        acts.delete();
        for (int k = 0; k < 3; k++)
            check_byte(got[k], pkt_byte(f, r, k), $sformatf("%s byte%0d", tag, k));
    endtask

    task automatic run_packet(input logic [8:0] f, input logic [3:0] r, input string tag);
        logic [8:0] cf;
        logic [3:0] cr;
        bit         more;
        string      t;
        cf   = f;
        cr   = r;
        more = 1'b1;
        t    = tag;
        while (more) begin
            recv(cf, cr, t);
            cyc();
            if (pend_valid_m && debug) begin
                cf           = pend_f_m;
                cr           = pend_r_m;
                pend_valid_m = 1'b0;
                t            = {tag, " pending"};
            end else begin
                more = 1'b0;
                check_bit(busy, 1'b0, {t, " busy drops after packet"});
                check_bit(tx, 1'b1, {t, " tx idle after packet"});
            end
        end
        check_bit(overrun, overrun_m, {tag, " overrun"});
    endtask

    task automatic pulse(input logic [8:0] f, input logic [3:0] r);
        debug_frame = f;
        debug_reg   = r;
        snap_valid  = 1'b1;
        cyc();
        snap_valid  = 1'b0;
    endtask

    initial begin
        logic [8:0] f;
        logic [3:0] r;
        rst         = 1'b1;
        debug       = 1'b0;
        snap_valid  = 1'b0;
        debug_frame = '0;
        debug_reg   = '0;
        repeat (3) cyc();
        check_bit(tx, 1'b1, "reset tx");
        check_bit(busy, 1'b0, "reset busy");
        check_bit(overrun, 1'b0, "reset overrun");
        rst = 1'b0;

        for (int c = 0; c < 200; c++) begin
            snap_valid  = 1'($urandom_range(0, 1));
            debug_frame = 9'($urandom_range(0, 511));
            debug_reg   = 4'($urandom_range(0, 15));
            cyc();
            check_bit(tx, 1'b1, "debug off tx");
            check_bit(busy, 1'b0, "debug off busy");
        end
        snap_valid = 1'b0;
        debug      = 1'b1;
        cyc();

        pulse(9'b010101010, 4'b0101);
        run_packet(9'b010101010, 4'b0101, "basic");

        pulse(9'b101010101, 4'b1111);
        add_act(0, ACT_ZERO_IN, '0, '0);
        run_packet(9'b101010101, 4'b1111, "latch");

        f = 9'($urandom_range(0, 511));
        r = 4'($urandom_range(0, 15));
        pulse(f, r);
        add_act(20, ACT_SNAP, 9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)));
        add_act(60, ACT_SNAP, 9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)));
        run_packet(f, r, "overwrite");

        f = 9'($urandom_range(0, 511));
        r = 4'($urandom_range(0, 15));
        pulse(f, r);
        add_act(10, ACT_SNAP, 9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)));
        add_act(50, ACT_DBG_OFF, '0, '0);
        run_packet(f, r, "debug drop");

        for (int c = 0; c < 10; c++) begin
            snap_valid = 1'b1;
            cyc();
            check_bit(busy, 1'b0, "ignored while debug low");
        end
        snap_valid = 1'b0;
        debug      = 1'b1;
        cyc();
        debug      = 1'b0;
        snap_valid = 1'b1;
        cyc();
        snap_valid = 1'b0;
        check_bit(busy, 1'b0, "snap with debug falling");
        check_bit(tx, 1'b1, "snap with debug falling tx");

        debug = 1'b1;
        cyc();
        pulse(9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)));
        repeat (50) cyc();
        check_bit(overrun, overrun_m, "overrun before reset");
        rst = 1'b1;
        cyc();
        rst          = 1'b0;
        overrun_m    = 1'b0;
        pend_valid_m = 1'b0;
        check_bit(tx, 1'b1, "reset mid-byte tx");
        check_bit(busy, 1'b0, "reset mid-byte busy");
        check_bit(overrun, 1'b0, "reset mid-byte overrun");
        for (int c = 0; c < 45; c++) begin
            cyc();
            check_bit(tx, 1'b1, "no resume after reset");
        end
        f = 9'($urandom_range(0, 511));
        r = 4'($urandom_range(0, 15));
        pulse(f, r);
        run_packet(f, r, "after reset");

        for (int p = 0; p < 5; p++) begin
            repeat ($urandom_range(1, 6)) cyc();
            f = 9'($urandom_range(0, 511));
            r = 4'($urandom_range(0, 15));
            pulse(f, r);
            if ($urandom_range(0, 1) == 1)
                add_act(int'($urandom_range(2, 100)), ACT_SNAP,
                        9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)));
            run_packet(f, r, $sformatf("random%0d", p));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
